// File: rtl/mdio_pkg.sv
// mdio_pkg: shared MDIO frame constants and FSM state type; MDIO_PREAMBLE_EN selects the 64-bit frame with preamble
package mdio_pkg;
    localparam logic [1:0] ST_CODE   = 2'b01;
    localparam logic [1:0] OP_RD     = 2'b10;
    localparam logic [1:0] OP_WR     = 2'b01;
    localparam logic [1:0] TA_WR     = 2'b10;
    localparam logic [5:0] PRE_LAST  = 6'd31;
    localparam logic [5:0] HDR_LAST  = 6'd13;
    localparam logic [5:0] TA_LAST   = 6'd1;
    localparam logic [5:0] DATA_LAST = 6'd15;
`ifdef MDIO_PREAMBLE_EN
    localparam int NBITS = 64;
`else
    localparam int NBITS = 32;
`endif
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA} state_t;
endpackage

// File: rtl/mdio_if.sv
// mdio_if: register-side request/response bus of the MDIO master
interface mdio_if;
    logic        mdio_valid;
    logic        mdio_write;
    logic        mdio_ready;
    logic [4:0]  mdio_addr;
    logic [15:0] mdio_wdata;
    logic [15:0] mdio_rdata;
    modport master(output mdio_valid, mdio_write, mdio_addr, mdio_wdata, input mdio_ready, mdio_rdata);
    modport slave(input mdio_valid, mdio_write, mdio_addr, mdio_wdata, output mdio_ready, mdio_rdata);
endinterface

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen: MDC generator with pre-edge rise/fall strobes, held low while disabled
module mdio_clk_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic mdc,
    output logic rise,
    output logic fall
);
    logic [7:0] cnt;
    logic       wrap;
    assign wrap = en && cnt == 8'(CLK_DIV - 1);
    assign rise = wrap && !mdc;
    assign fall = wrap && mdc;
    // half-period counter; MDC toggles each time it wraps
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= 8'd0;
            mdc <= 1'b0;
        end else if (wrap) begin
            cnt <= 8'd0;
            mdc <= ~mdc;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO master; MDIO_PREAMBLE_EN adds the 32-bit all-ones preamble
module mdio_master
    import mdio_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd0,
    parameter int         CLK_DIV  = 50
) (
    input  logic clk,
    input  logic rst,
    mdio_if.slave bus,
    output logic mdio_phy_c,
    output logic mdio_phy_o,
    output logic mdio_phy_t,
    input  logic mdio_phy_i
);
    state_t      state, state_n;
    logic [5:0]  bit_cnt, cnt_n;
    logic [31:0] sr, sr_n, frame;
    logic [15:0] rd_sr, rd_n, rdata, rdata_n;
    logic        wr, wr_n, o_n, t_n, accept, last, rise, fall;

    mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk(clk),
        .rst(rst),
        .en(state != S_IDLE),
        .mdc(mdio_phy_c),
        .rise(rise),
        .fall(fall)
    );

    assign bus.mdio_ready = state == S_IDLE;
    assign bus.mdio_rdata = rdata;
    assign accept = state == S_IDLE && bus.mdio_valid;
    assign frame  = {ST_CODE, bus.mdio_write ? OP_WR : OP_RD, PHY_ADDR, bus.mdio_addr, TA_WR,
                     bus.mdio_write ? bus.mdio_wdata : 16'h0000};
    assign last   = bit_cnt == (state == S_PRE ? PRE_LAST : state == S_HDR ? HDR_LAST :
                                state == S_TA ? TA_LAST : DATA_LAST);

    // next-state: bit boundaries happen on MDC fall, read samples on MDC rise
    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        sr_n    = sr;
        wr_n    = wr;
        rd_n    = rd_sr;
        o_n     = mdio_phy_o;
        t_n     = mdio_phy_t;
        rdata_n = rdata;
        if (accept) begin
            wr_n  = bus.mdio_write;
            sr_n  = frame;
            cnt_n = 6'd0;
            t_n   = 1'b0;
`ifdef MDIO_PREAMBLE_EN
            state_n = S_PRE;
            o_n     = 1'b1;
`else
            state_n = S_HDR;
            o_n     = frame[31];
`endif
        end
        if (rise && state == S_DATA)
            rd_n = {rd_sr[14:0], mdio_phy_i};
        if (fall) begin
            cnt_n = last ? 6'd0 : bit_cnt + 6'd1;
            sr_n  = state == S_PRE ? sr : {sr[30:0], 1'b0};
            o_n   = state == S_PRE ? (last ? sr[31] : 1'b1) : sr[30];
            if (last) begin
                state_n = state == S_PRE ? S_HDR : state == S_HDR ? S_TA : state == S_TA ? S_DATA : S_IDLE;
                if (state == S_HDR)
                    t_n = !wr;
                if (state == S_DATA) begin
                    o_n     = 1'b1;
                    t_n     = 1'b1;
                    rdata_n = wr ? rdata : rd_sr;
                end
            end
        end
    end

    // state and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= 6'd0;
            sr         <= 32'h0;
            wr         <= 1'b0;
            rd_sr      <= 16'h0;
            mdio_phy_o <= 1'b1;
            mdio_phy_t <= 1'b1;
            rdata      <= 16'h0;
        end else begin
            state      <= state_n;
            bit_cnt    <= cnt_n;
            sr         <= sr_n;
            wr         <= wr_n;
            rd_sr      <= rd_n;
            mdio_phy_o <= o_n;
            mdio_phy_t <= t_n;
            rdata      <= rdata_n;
        end
    end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed self-checking bench for mdio_master with a bit-level PHY model
`timescale 1ns/1ps
module tb_mdio_master;
`ifdef MDIO_PREAMBLE_EN
    localparam int PRE = 32;
`else
    localparam int PRE = 0;
`endif
    localparam int NB = PRE + 32;
    localparam int ABIT = PRE + 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic phy_i = 1'b1;
    logic phy_c, phy_o, phy_t;
    int checks = 0;
    int errors = 0;

    mdio_if bus();

    mdio_master #(.PHY_ADDR(5'd1), .CLK_DIV(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .mdio_phy_c(phy_c),
        .mdio_phy_o(phy_o),
        .mdio_phy_t(phy_t),
        .mdio_phy_i(phy_i)
    );

    always #5 clk = ~clk;

    int k = 0;
    int k_base = 0;
    int rel = 0;
    int hi_run = 0;
    int lo_run = 0;
    int bad_hi = 0;
    int bad_lo = 0;
    logic prev_c = 1'b0;
    logic [15:0] phy_val = 16'h0;
    logic cap_o [0:1023];
    logic cap_t [0:1023];

    // PHY model: captures MDIO at each MDC rise, drives read data after each MDC fall, measures MDC phases
    always @(negedge clk) begin
        if (!prev_c && phy_c) begin
            if (k < 1024) begin
                cap_o[k] = phy_o;
                cap_t[k] = phy_t;
            end
            k++;
            if (lo_run != 2) bad_lo++;
            lo_run = 0;
        end
        if (prev_c && !phy_c) begin
            if (hi_run != 2) bad_hi++;
            hi_run = 0;
            rel = k - k_base;
            phy_i = (rel >= PRE + 16 && rel < PRE + 32) ? phy_val[4'(PRE + 31 - rel)] : 1'b1;
        end
        if (phy_c) hi_run++;
        else if (!bus.mdio_ready) lo_run++;
        else lo_run = 0;
        prev_c = phy_c;
    end

    function automatic logic [63:0] exp_frame(input logic w, input logic [4:0] a, input logic [15:0] d);
        logic [63:0] e;
        e = {32'hFFFF_FFFF, 2'b01, w ? 2'b01 : 2'b10, 5'd1, a, 2'b10, w ? d : 16'h0};
        if (PRE == 0) e[63:32] = 32'h0;
        return e;
    endfunction

    function automatic logic [63:0] hdr_mask();
        logic [63:0] m;
        m = ~64'h0 << 18;
        if (PRE == 0) m[63:32] = 32'h0;
        return m;
    endfunction

    function automatic logic [63:0] got_o(input int base);
        logic [63:0] g = 64'h0;
        for (int i = 0; i < NB; i++) g = {g[62:0], cap_o[base + i]};
        return g;
    endfunction

    function automatic logic [63:0] got_t(input int base);
        logic [63:0] g = 64'h0;
        for (int i = 0; i < NB; i++) g = {g[62:0], cap_t[base + i]};
        return g;
    endfunction

    task automatic run_req(input logic w, input logic [4:0] a, input logic [15:0] d,
                           output int low, output logic [15:0] rd);
        @(negedge clk);
        k_base = k;
        bus.mdio_valid = 1'b1;
        bus.mdio_write = w;
        bus.mdio_addr  = a;
        bus.mdio_wdata = d;
        @(negedge clk);
        bus.mdio_valid = 1'b0;
        low = 0;
        while (!bus.mdio_ready && low < 2000) begin
            low++;
            @(negedge clk);
        end
        rd = bus.mdio_rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mdio_valid = 1'b1;
        bus.mdio_write = 1'b1;
        bus.mdio_addr  = 5'h3;
        bus.mdio_wdata = 16'hBEEF;
        repeat (3) @(negedge clk);
        checks++; if (bus.mdio_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.mdio_ready); end
        checks++; if (bus.mdio_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0000", bus.mdio_rdata); end
        checks++; if (phy_c !== 1'b0) begin errors++; $display("FAIL reset_mdc got %b exp 0", phy_c); end
        checks++; if (phy_o !== 1'b1) begin errors++; $display("FAIL reset_o got %b exp 1", phy_o); end
        checks++; if (phy_t !== 1'b1) begin errors++; $display("FAIL reset_t got %b exp 1", phy_t); end
        bus.mdio_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        int n = 0;
        @(negedge clk);
        k_base = k;
        phy_val = 16'hFFFF;
        bus.mdio_valid = 1'b1;
        bus.mdio_write = 1'b0;
        bus.mdio_addr  = 5'h02;
        @(negedge clk);
        bus.mdio_valid = 1'b0;
        while ((k - k_base) < ABIT && n < 2000) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n >= 2000) begin errors++; $display("FAIL abort_reach got %0d rises exp %0d", k - k_base, ABIT); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.mdio_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", bus.mdio_ready); end
        checks++; if (phy_t !== 1'b1) begin errors++; $display("FAIL abort_t got %b exp 1", phy_t); end
        checks++; if (phy_c !== 1'b0) begin errors++; $display("FAIL abort_mdc got %b exp 0", phy_c); end
        checks++; if (phy_o !== 1'b1) begin errors++; $display("FAIL abort_o got %b exp 1", phy_o); end
        checks++; if (bus.mdio_rdata !== 16'h0) begin errors++; $display("FAIL abort_rdata got %h exp 0000", bus.mdio_rdata); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write(input logic [4:0] a, input logic [15:0] d);
        int low;
        logic [15:0] rd;
        run_req(1'b1, a, d, low, rd);
        checks++; if (low !== NB * 4) begin errors++; $display("FAIL wr_busy_cycles got %0d exp %0d", low, NB * 4); end
        checks++; if (k - k_base !== NB) begin errors++; $display("FAIL wr_mdc_rises got %0d exp %0d", k - k_base, NB); end
        checks++; if (got_o(k_base) !== exp_frame(1'b1, a, d)) begin errors++; $display("FAIL wr_stream got %h exp %h", got_o(k_base), exp_frame(1'b1, a, d)); end
        checks++; if (got_t(k_base) !== 64'h0) begin errors++; $display("FAIL wr_tristate got %h exp 0", got_t(k_base)); end
        checks++; if ({phy_c, phy_o, phy_t} !== 3'b011) begin errors++; $display("FAIL wr_end_pins got %b exp 011", {phy_c, phy_o, phy_t}); end
        checks++; if (rd !== 16'h0) begin errors++; $display("FAIL wr_rdata got %h exp 0000", rd); end
    endtask

    task automatic test_read();
        int low;
        logic [15:0] rd;
        phy_val = 16'h4F51;
        run_req(1'b0, 5'h02, 16'h0, low, rd);
        checks++; if (low !== NB * 4) begin errors++; $display("FAIL rd_busy_cycles got %0d exp %0d", low, NB * 4); end
        checks++; if ((got_o(k_base) & hdr_mask()) !== (exp_frame(1'b0, 5'h02, 16'h0) & hdr_mask())) begin errors++; $display("FAIL rd_header got %h exp %h", got_o(k_base) & hdr_mask(), exp_frame(1'b0, 5'h02, 16'h0) & hdr_mask()); end
        checks++; if (got_t(k_base) !== 64'h3FFFF) begin errors++; $display("FAIL rd_tristate got %h exp 3ffff", got_t(k_base)); end
        checks++; if (rd !== 16'h4F51) begin errors++; $display("FAIL rd_data got %h exp 4f51", rd); end
        checks++; if ({phy_c, phy_o, phy_t} !== 3'b011) begin errors++; $display("FAIL rd_end_pins got %b exp 011", {phy_c, phy_o, phy_t}); end
    endtask

    task automatic test_busy_ignore();
        int low = 0;
        @(negedge clk);
        k_base = k;
        phy_val = 16'hA5C3;
        bus.mdio_valid = 1'b1;
        bus.mdio_write = 1'b0;
        bus.mdio_addr  = 5'h02;
        @(negedge clk);
        bus.mdio_valid = 1'b0;
        while (!bus.mdio_ready && low < 2000) begin
            low++;
            bus.mdio_valid = low == 30;
            bus.mdio_write = low == 30;
            bus.mdio_addr  = low == 30 ? 5'h1F : 5'h02;
            @(negedge clk);
        end
        bus.mdio_valid = 1'b0;
        checks++; if (low !== NB * 4) begin errors++; $display("FAIL ign_busy_cycles got %0d exp %0d", low, NB * 4); end
        checks++; if ((got_o(k_base) & hdr_mask()) !== (exp_frame(1'b0, 5'h02, 16'h0) & hdr_mask())) begin errors++; $display("FAIL ign_header got %h exp %h", got_o(k_base) & hdr_mask(), exp_frame(1'b0, 5'h02, 16'h0) & hdr_mask()); end
        checks++; if (got_t(k_base) !== 64'h3FFFF) begin errors++; $display("FAIL ign_tristate got %h exp 3ffff", got_t(k_base)); end
        checks++; if (bus.mdio_rdata !== 16'hA5C3) begin errors++; $display("FAIL ign_rdata got %h exp a5c3", bus.mdio_rdata); end
        @(negedge clk);
        checks++; if (bus.mdio_ready !== 1'b1) begin errors++; $display("FAIL ign_no_queue got ready %b exp 1", bus.mdio_ready); end
    endtask

    task automatic test_back_to_back();
        int low1 = 0;
        int low2 = 0;
        int b2;
        int hi0, lo0;
        @(negedge clk);
        hi0 = bad_hi;
        lo0 = bad_lo;
        k_base = k;
        bus.mdio_valid = 1'b1;
        bus.mdio_write = 1'b1;
        bus.mdio_addr  = 5'h03;
        bus.mdio_wdata = 16'hA5A5;
        @(negedge clk);
        while (!bus.mdio_ready && low1 < 2000) begin
            low1++;
            @(negedge clk);
        end
        b2 = k;
        bus.mdio_addr  = 5'h04;
        bus.mdio_wdata = 16'h1234;
        @(negedge clk);
        checks++; if (bus.mdio_ready !== 1'b0) begin errors++; $display("FAIL b2b_gap got ready %b exp 0", bus.mdio_ready); end
        bus.mdio_valid = 1'b0;
        while (!bus.mdio_ready && low2 < 2000) begin
            low2++;
            @(negedge clk);
        end
        checks++; if (low1 !== NB * 4) begin errors++; $display("FAIL b2b_busy1 got %0d exp %0d", low1, NB * 4); end
        checks++; if (low2 !== NB * 4) begin errors++; $display("FAIL b2b_busy2 got %0d exp %0d", low2, NB * 4); end
        checks++; if (got_o(k_base) !== exp_frame(1'b1, 5'h03, 16'hA5A5)) begin errors++; $display("FAIL b2b_frame1 got %h exp %h", got_o(k_base), exp_frame(1'b1, 5'h03, 16'hA5A5)); end
        checks++; if (got_o(b2) !== exp_frame(1'b1, 5'h04, 16'h1234)) begin errors++; $display("FAIL b2b_frame2 got %h exp %h", got_o(b2), exp_frame(1'b1, 5'h04, 16'h1234)); end
        checks++; if (bad_hi - hi0 !== 0) begin errors++; $display("FAIL b2b_mdc_high got %0d bad phases exp 0", bad_hi - hi0); end
        checks++; if (bad_lo - lo0 !== 0) begin errors++; $display("FAIL b2b_mdc_low got %0d bad phases exp 0", bad_lo - lo0); end
        checks++; if (bus.mdio_rdata !== 16'hA5C3) begin errors++; $display("FAIL b2b_rdata got %h exp a5c3", bus.mdio_rdata); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.mdio_valid = 1'b0;
        bus.mdio_write = 1'b0;
        bus.mdio_addr  = 5'h0;
        bus.mdio_wdata = 16'h0;
        test_reset();
        test_abort();
        test_write(5'h00, 16'h1140);
        test_write(5'h1F, 16'hFFFF);
        test_read();
        test_busy_ignore();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd0, Clause-22 PHY address placed in every frame.
REQ-002 SHALL have parameter CLK_DIV, default 50, clk cycles per MDC half-period (125 MHz -> 1.25 MHz MDC); legal range 2..255.
REQ-003 SHALL have port clk  input  1  system clock, 125 MHz; single clock domain.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port mdio_valid  input  1  request strobe from register interface.
REQ-006 SHALL have port mdio_write  input  1  1 = write, 0 = read; qualified by mdio_valid.
REQ-007 SHALL have port mdio_ready  output  1  high = idle, able to accept a request.
REQ-008 SHALL have port mdio_addr  input  5  PHY register address.
REQ-009 SHALL have port mdio_wdata  input  16  write data.
REQ-010 SHALL have port mdio_rdata  output  16  read data, held until the next read completes.
REQ-011 SHALL have port mdio_phy_c  output  1  MDC.
REQ-012 SHALL have port mdio_phy_o  output  1  MDIO output value.
REQ-013 SHALL have port mdio_phy_t  output  1  tristate enable; 1 = released (Z).
REQ-014 SHALL have port mdio_phy_i  input  1  MDIO pad input.

Function
REQ-015 SHALL accept a request on the cycle mdio_valid && mdio_ready; it SHALL capture addr, wdata and write on that cycle and drive mdio_ready low from the next cycle.
REQ-016 SHALL ignore mdio_valid while mdio_ready is low; there is no queue.
REQ-017 SHALL drive frame bits MSB first: preamble (REQ-030), ST=01, OP=10 read / 01 write, PHYAD=PHY_ADDR, REGAD=mdio_addr, TA, then 16 data bits.
REQ-018 SHALL generate each MDC bit as CLK_DIV cycles low followed by CLK_DIV cycles high; mdio_phy_c SHALL be low while idle.
REQ-019 SHALL update mdio_phy_o only on the cycle MDC goes low, giving CLK_DIV cycles of setup and hold around the MDC rising edge.
REQ-020 SHALL, on writes, drive TA=10 and the data with mdio_phy_t=0 throughout the frame.
REQ-021 SHALL, on reads, set mdio_phy_t=1 from the first TA bit through the last data bit; it SHALL sample mdio_phy_i on the cycle MDC goes high for each data bit and ignore TA samples.
REQ-022 SHALL use states IDLE -> PRE -> HDR (14 bits ST..REGAD) -> TA (2 bits) -> DATA (16 bits) -> IDLE, using a 6-bit bit counter; PRE SHALL be skipped when REQ-030 is disabled.
REQ-023 SHALL, after the last data bit's high phase, drive mdio_phy_c low, mdio_phy_t=1 and mdio_phy_o=1; on reads it SHALL load mdio_rdata, all on the same cycle that mdio_ready returns high.
REQ-024 SHALL hold mdio_ready low for exactly NBITS*2*CLK_DIV cycles, with NBITS=64 when preamble is enabled and 32 otherwise.
REQ-025 SHALL leave mdio_rdata unchanged by write transactions.
REQ-026 SHALL accept a new request on the same cycle mdio_ready rises; back-to-back frames are allowed.

Reset
REQ-027 SHALL reset to: mdio_ready=1, mdio_rdata=0, mdio_phy_c=0, mdio_phy_o=1, mdio_phy_t=1, state IDLE, counters 0.
REQ-028 SHALL, on rst asserted mid-frame, abort the frame and show reset values on the cycle after rst is sampled; the partial read data SHALL be discarded.
REQ-029 SHALL give rst priority over a simultaneous mdio_valid.

Configuration
REQ-030 SHALL send a 32-bit all-ones preamble (mdio_phy_t=0) before ST when macro MDIO_PREAMBLE_EN is defined; when it is undefined, the frame SHALL start at ST (preamble suppression, 32-bit frames).

Structure
REQ-031 SHALL take ST/OP code constants, TA pattern, state enum and frame-length constants from shared package mdio_pkg.
REQ-032 SHALL contain one sub-module, mdio_clk_gen, producing MDC plus one-cycle rise/fall strobes from CLK_DIV, reset to MDC low, and running only while busy.

Verification (CLK_DIV=2, PHY_ADDR=5'd1, macro defined unless stated)
REQ-033 SHALL cover: write addr=0x00, wdata=0x1140 -> MDIO bit stream 32x1, 01, 01, 00001, 00000, 10, 0001000101000000; mdio_phy_t=0 throughout; ready low for exactly 256 cycles.
REQ-034 SHALL cover: read addr=0x02 with the PHY model returning 0x4F51 -> OP=10, mdio_phy_t=1 from TA onward, mdio_rdata=0x4F51 on the cycle ready rises.
REQ-035 SHALL cover: mdio_valid pulsed while busy with a different addr -> ignored, and the frame in flight is unchanged.
REQ-036 SHALL cover: rst asserted at bit 40 of a read -> next cycle ready=1, phy_t=1, phy_c=0, rdata keeps its prior value of 0.
REQ-037 SHALL cover: macro undefined, write addr=0x1F, wdata=0xFFFF -> no preamble; frame starts with 01; ready low for 128 cycles.
REQ-038 SHALL cover: two back-to-back requests on ready rise -> second frame starts with no idle MDC cycle; MDC high and low phases each exactly 2 cycles.
